// File: rtl/arbiter_pkg.sv
// Shared definitions for the arbiter / stream concentrator slice.
//   mux_state_e    : transfer tracking state of arbiter_stream_mux
//   arb_sel_width  : width of a port index for n ports (at least 1 bit)
package arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StGap
  } mux_state_e;

  function automatic int unsigned arb_sel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stream_skid.sv
// Two-entry register slice with a registered ready.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_data    : upstream beat, accepted when in_valid & in_ready
//   in_ready            : registered; high whenever at least one entry is free
//   out_valid/out_data  : head entry; held stable while out_ready is low
//   out_ready           : downstream accept
module stream_skid #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready
);

  logic [WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       count_q, count_d;
  logic             ready_q;
  logic             push, pop;

  assign push = in_valid & ready_q;
  assign pop  = (count_q != 2'd0) & out_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    case (count_q)
      2'd0: begin
        if (push) begin
          head_d  = in_data;
          count_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          head_d = in_data;
        end else if (push) begin
          tail_d  = in_data;
          count_d = 2'd2;
        end else if (pop) begin
          count_d = 2'd0;
        end
      end
      default: begin
        // Full: ready_q is low, so only a pop can happen here.
        if (pop) begin
          head_d  = tail_q;
          count_d = 2'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= 2'd0;
      ready_q <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      // Ready for next cycle is decided from occupancy only, never from out_ready.
      ready_q <= (count_d != 2'd2);
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;

endmodule

// File: rtl/arbiter_stream_mux.sv
// Stream concentrator paired with a registered round-robin arbiter.
// Turns per-port valid/data/last streams into arbiter requests, forwards beats
// from the granted port into a 2-entry output skid, and drops a port's request
// for one cycle after a release beat so the arbiter token moves on.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_data/in_last   : per-port input streams (port i at [i*DATA_WIDTH +: DATA_WIDTH])
//   in_ready                   : per-port accept
//   arb_request                : to arbiter request
//   arb_grant/select/active    : registered arbiter outputs
//   out_valid/data/last/port   : shared output stream, out_port = source port
//   out_ready                  : downstream accept
// Build option: ARB_MUX_PKT_LOCK_EN defined -> release only on in_last (packet lock);
// undefined -> every accepted beat releases (per-beat round robin).
module arbiter_stream_mux
  import arbiter_pkg::*;
#(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = arb_sel_width(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_last,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [NUM_PORTS-1:0]            arb_request,
  input  logic [NUM_PORTS-1:0]            arb_grant,
  input  logic [SEL_WIDTH-1:0]            arb_select,
  input  logic                            arb_active,
  output logic                            out_valid,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_last,
  output logic [SEL_WIDTH-1:0]            out_port,
  input  logic                            out_ready
);

  localparam int unsigned SkidWidth = DATA_WIDTH + 1 + SEL_WIDTH;

  logic [NUM_PORTS-1:0]  hold_q, hold_d;
  logic [NUM_PORTS-1:0]  take;
  logic                  skid_ready, grant_ok, take_any, take_last, rel_beat;
  logic [DATA_WIDTH-1:0] take_data;
  logic [SkidWidth-1:0]  skid_in, skid_out;
  mux_state_e            state_q, state_d;

  assign arb_request = rst ? '0 : (in_valid & ~hold_q);

  // hold masks the stale grant the arbiter still presents the cycle after a release.
  assign grant_ok = arb_active & skid_ready & ~rst;
  assign in_ready = arb_grant & ~hold_q & {NUM_PORTS{grant_ok}};
  assign take     = in_ready & in_valid;
  assign take_any = |take;

  // Grant is one-hot, so at most one take bit selects the payload.
  always_comb begin
    take_data = '0;
    take_last = 1'b0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (take[i]) begin
        take_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
        take_last = in_last[i];
      end
    end
  end

`ifdef ARB_MUX_PKT_LOCK_EN
  assign rel_beat = take_any & take_last;
`else
  assign rel_beat = take_any;
`endif

  assign hold_d = rel_beat ? take : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (take_any) begin
          state_d = rel_beat ? StGap : StXfer;
        end
      end
      StXfer: begin
        if (rel_beat) begin
          state_d = StGap;
        end
      end
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q  <= '0;
      state_q <= StIdle;
    end else begin
      hold_q  <= hold_d;
      state_q <= state_d;
    end
  end

  assign skid_in = {take_data, take_last, arb_select};

  stream_skid #(
    .WIDTH(SkidWidth)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (take_any),
    .in_data   (skid_in),
    .in_ready  (skid_ready),
    .out_valid (out_valid),
    .out_data  (skid_out),
    .out_ready (out_ready)
  );

  assign {out_data, out_last, out_port} = skid_out;

`ifndef SYNTHESIS
  // A grant that moves mid-packet would interleave packets; this block cannot recover.
  logic [NUM_PORTS-1:0] xfer_grant_q;

  always_ff @(posedge clk) begin
    if (take_any) begin
      xfer_grant_q <= arb_grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && (state_q == StXfer)) begin
      assert (arb_grant == xfer_grant_q);
    end
  end
`endif

endmodule
